wptr_full_ctrl: RTL and testbench
=================================

// Module: wptr_full_ctrl
// PURPOSE
//  Write-side pointer and status generator for the async FIFO, clocked by wclk.
//  - Consumes the 2-flop-synchronised Gray read pointer (wq2_rptr) from the write-domain synchroniser.
//  - Produces the binary RAM write address and the Gray write pointer sent to the read-domain synchroniser.
//  - Produces full, almost-full, fill-level and overflow status. Full is pessimistic by design.
// PARAMETERS
//  PTR_WIDTH  11  pointer width; address width = PTR_WIDTH-1; DEPTH = 2**(PTR_WIDTH-1)
//  AF_MARGIN  4   walmost_full asserts when wlevel >= DEPTH-AF_MARGIN (1..DEPTH-1)
// PORTS
//  wclk          in   1            write-domain clock
//  wrst          in   1            synchronous reset, active-high
//  winc          in   1            write request from producer
//  wovf_clr      in   1            clears sticky woverflow
//  wq2_rptr      in   PTR_WIDTH    synchronised Gray read pointer
//  wen           out  1            RAM write strobe, combinational: winc & ~wfull
//  waddr         out  PTR_WIDTH-1  RAM write address (wbin[PTR_WIDTH-2:0])
//  wptr_g        out  PTR_WIDTH    registered Gray write pointer, to read-side synchroniser
//  wfull         out  1            FIFO full, registered
//  walmost_full  out  1            almost-full, registered
//  wlevel        out  PTR_WIDTH    fill level 0..DEPTH as seen from write side, registered
//  woverflow     out  1            sticky: a write was attempted while full
// BEHAVIOUR
//  - Reset (wrst=1 at posedge wclk): wbin, wptr_g, wlevel = 0; wfull, walmost_full, woverflow = 0.
//    Reset takes priority over any other input in that cycle, including mid-burst.
//  - Write accept: wen = winc & ~wfull. A write is accepted only on a cycle where wen=1.
//  - Next-state values:
//    - wbin_next = wbin + wen (modulo 2**PTR_WIDTH, natural wrap).
//    - wgray_next = wbin_next ^ (wbin_next >> 1).
//    - wptr_g <= wgray_next. Only one bit changes per increment.
//  - Full:
//    - wfull <= (wgray_next == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]}).
//    - wfull is therefore valid the cycle after the DEPTH-th accepted write.
//  - Level:
//    - rbin = gray2bin(wq2_rptr).
//    - wlevel <= wbin_next - rbin, computed in PTR_WIDTH bits modulo 2**PTR_WIDTH. Result is always in 0..DEPTH.
//  - Almost-full: walmost_full <= ((wbin_next - rbin) >= DEPTH-AF_MARGIN).
//  - Overflow: winc & wfull drops the write (wen=0; waddr and wptr_g unchanged).
//    - woverflow <= 1 on the next cycle and holds until wovf_clr or reset.
//    - If set and clear occur in the same cycle, set wins.
//  - Read pointer advance: reads become visible only via wq2_rptr, so wfull deasserts 1 wclk after
//    wq2_rptr advances. wfull never deasserts early (pessimistic, never optimistic).
//  - Simultaneous winc and wq2_rptr advance while full: the write is rejected, because wfull is from
//    the previous cycle. wfull clears next cycle.
//  - wq2_rptr is assumed Gray-coded and monotonic. No checking is done on it.
// STRUCTURE
//  - Shared package fifo_pkg:
//    - bin2gray and gray2bin functions, parameterised on width.
//    - Pointer-width localparams (ADDR_W = PTR_WIDTH-1, DEPTH).
//  - No sub-module. One always block for registers, combinational next-state logic alongside it.
//  - Top-level FIFO instantiates this next to the write-domain synchroniser and the dual-port RAM.
// TESTING (bench with PTR_WIDTH=4, DEPTH=8, AF_MARGIN=2)
//  1. Reset: hold wrst=1 with winc=1 for 3 cycles -> all outputs 0 and waddr=0 throughout.
//  2. Fill, wq2_rptr=0000, 8 back-to-back winc -> after write 6 walmost_full=1 and wlevel=6;
//     after write 8 wfull=1, wptr_g=4'b1100, wlevel=8.
//  3. Overflow: winc while wfull=1 -> wen=0, waddr stays 0, woverflow=1 next cycle;
//     pulse wovf_clr -> woverflow=0.
//  4. Drain/wrap: set wq2_rptr=4'b1100 -> wfull=0 and wlevel=0 next cycle; 8 more writes ->
//     wbin wraps 15->0, wptr_g=4'b0000, wfull=1.
//  5. Simultaneous: at full, winc=1 in the same cycle wq2_rptr advances by one ->
//     that write dropped, wfull=0 next cycle, following winc accepted.
//  6. Mid-burst reset: wrst=1 after 5 writes -> next cycle wlevel=0, wptr_g=0, walmost_full=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default pointer geometry and Gray/binary conversion.
// The converters work on a CODE_W-wide zero-extended value, so any pointer width up to CODE_W can use them.
package fifo_pkg;

    localparam int PTR_WIDTH_DFLT = 11;
    localparam int ADDR_W         = PTR_WIDTH_DFLT - 1;
    localparam int DEPTH          = 1 << ADDR_W;
    localparam int CODE_W         = 32;

    function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Leading zeros leave the prefix XOR unchanged, so narrower pointers convert correctly.
    function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] gray);
        logic [CODE_W-1:0] bin;
        bin[CODE_W-1] = gray[CODE_W-1];
        for (int i = CODE_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and status logic for the async FIFO.
// Produces the RAM write address, the Gray pointer to cross into the read domain, and full/level/overflow status.
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH = PTR_WIDTH_DFLT,
    parameter int AF_MARGIN = 4
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 winc,
    input  logic                 wovf_clr,
    input  logic [PTR_WIDTH-1:0] wq2_rptr,
    output logic                 wen,
    output logic [PTR_WIDTH-2:0] waddr,
    output logic [PTR_WIDTH-1:0] wptr_g,
    output logic                 wfull,
    output logic                 walmost_full,
    output logic [PTR_WIDTH-1:0] wlevel,
    output logic                 woverflow
);

    localparam int                   ENTRIES  = 1 << (PTR_WIDTH - 1);
    localparam logic [PTR_WIDTH-1:0] AF_LEVEL = PTR_WIDTH'(ENTRIES - AF_MARGIN);

    logic [PTR_WIDTH-1:0] wbin;
    logic [PTR_WIDTH-1:0] wbin_next;
    logic [PTR_WIDTH-1:0] wgray_next;
    logic [PTR_WIDTH-1:0] rbin;
    logic [PTR_WIDTH-1:0] level_next;
    logic [PTR_WIDTH-1:0] full_ptr;
    logic                 full_next;
    logic                 almost_next;

    assign wen   = winc & ~wfull;
    assign waddr = wbin[PTR_WIDTH-2:0];

    // Full is judged against the synchronised (stale) read pointer, so it can only ever be late to clear.
    always_comb begin
        wbin_next   = wbin + PTR_WIDTH'(wen);
        wgray_next  = PTR_WIDTH'(bin2gray(CODE_W'(wbin_next)));
        rbin        = PTR_WIDTH'(gray2bin(CODE_W'(wq2_rptr)));
        level_next  = wbin_next - rbin;
        full_ptr    = {~wq2_rptr[PTR_WIDTH-1 -: 2], wq2_rptr[PTR_WIDTH-3:0]};
        full_next   = (wgray_next == full_ptr);
        almost_next = (level_next >= AF_LEVEL);
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin         <= '0;
            wptr_g       <= '0;
            wlevel       <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            wptr_g       <= wgray_next;
            wlevel       <= level_next;
            wfull        <= full_next;
            walmost_full <= almost_next;
            woverflow    <= (winc & wfull) | (woverflow & ~wovf_clr);
        end
    end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Bench for wptr_full_ctrl at PTR_WIDTH=4 (8 entries), AF_MARGIN=2.
// Reference model counts writes and reads as plain integers; the FIFO level is simply their difference.
module tb_wptr_full_ctrl;

    logic       wclk = 1'b0;
    logic       wrst;
    logic       winc;
    logic       wovfClr;
    logic [3:0] wq2Rptr;
    logic       wen;
    logic [2:0] waddr;
    logic [3:0] wptrG;
    logic       wfull;
    logic       walmostFull;
    logic [3:0] wlevel;
    logic       woverflow;

    int total = 0;
    int bad   = 0;

    int mWr    = 0;
    int mRd    = 0;
    int mLevel = 0;
    bit mFull  = 1'b0;
    bit mAf    = 1'b0;
    bit mOvf   = 1'b0;
    int rdCount;

    logic [3:0] grayTab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    wptr_full_ctrl #(
        .PTR_WIDTH (4),
        .AF_MARGIN (2)
    ) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .winc         (winc),
        .wovf_clr     (wovfClr),
        .wq2_rptr     (wq2Rptr),
        .wen          (wen),
        .waddr        (waddr),
        .wptr_g       (wptrG),
        .wfull        (wfull),
        .walmost_full (walmostFull),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    always #5 wclk = ~wclk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic checkOutput();
        checkVal("waddr", 32'(waddr), 32'(mWr % 8));
        checkVal("wptr_g", 32'(wptrG), 32'(grayTab[mWr % 16]));
        checkVal("wfull", 32'(wfull), 32'(mFull));
        checkVal("walmost_full", 32'(walmostFull), 32'(mAf));
        checkVal("wlevel", 32'(wlevel), 32'(mLevel));
        checkVal("woverflow", 32'(woverflow), 32'(mOvf));
    endtask

    // Drive one cycle of inputs, check the combinational strobe, clock, advance the model, check registers.
    task automatic applyStimulus(input bit inc, input bit clr, input bit rst, input int rdTarget);
        bit wasFull;
        winc    = inc;
        wovfClr = clr;
        wrst    = rst;
        mRd     = rdTarget;
        wq2Rptr = grayTab[rdTarget % 16];
        #1;
        if (!rst) checkVal("wen", 32'(wen), 32'(inc && !mFull));
        @(posedge wclk);
        wasFull = mFull;
        if (rst) begin
            mWr    = 0;
            mLevel = 0;
            mFull  = 1'b0;
            mAf    = 1'b0;
            mOvf   = 1'b0;
        end else begin
            if (inc && !wasFull) mWr++;
            mLevel = mWr - mRd;
            mFull  = (mLevel == 8);
            mAf    = (mLevel >= 6);
            mOvf   = (inc && wasFull) || (mOvf && !clr);
        end
        #1;
        checkOutput();
    endtask

    initial begin
        rdCount = 0;

        // Reset held with a write request pending
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 0);

        // Fill from empty
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 0);
            if (i == 5) checkVal("af_below", 32'(walmostFull), 32'd0);
            if (i == 6) begin
                checkVal("af_at6", 32'(walmostFull), 32'd1);
                checkVal("level6", 32'(wlevel), 32'd6);
            end
            if (i == 7) checkVal("notfull7", 32'(wfull), 32'd0);
        end
        checkVal("fill_gray", 32'(wptrG), 32'hC);
        checkVal("fill_full", 32'(wfull), 32'd1);
        checkVal("fill_level", 32'(wlevel), 32'd8);

        // Overflow, set beating clear, then clear
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        checkVal("ovf_waddr", 32'(waddr), 32'd0);
        checkVal("ovf_set", 32'(woverflow), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 0);
        checkVal("ovf_set_wins", 32'(woverflow), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkVal("ovf_clr", 32'(woverflow), 32'd0);

        // Drain everything, then refill through the pointer wrap
        applyStimulus(1'b0, 1'b0, 1'b0, 8);
        checkVal("drain_full", 32'(wfull), 32'd0);
        checkVal("drain_level", 32'(wlevel), 32'd0);
        repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, 8);
        checkVal("wrap_gray", 32'(wptrG), 32'h0);
        checkVal("wrap_full", 32'(wfull), 32'd1);

        // Write coinciding with a read-pointer advance while full
        applyStimulus(1'b1, 1'b0, 1'b0, 9);
        checkVal("simul_dropped", 32'(waddr), 32'd0);
        checkVal("simul_unfull", 32'(wfull), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 9);
        checkVal("simul_accept", 32'(wptrG), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b0, 9);

        // Reset in the middle of a burst
        applyStimulus(1'b0, 1'b0, 1'b1, 0);
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 0);
        checkVal("mid_rst_level", 32'(wlevel), 32'd0);
        checkVal("mid_rst_gray", 32'(wptrG), 32'd0);
        checkVal("mid_rst_af", 32'(walmostFull), 32'd0);

        // Random traffic with a lagging, monotonic read pointer
        rdCount = 0;
        for (int n = 0; n < 400; n++) begin
            bit doRst;
            bit doInc;
            bit doClr;
            doRst = ($urandom_range(0, 99) == 0);
            doInc = ($urandom_range(0, 9) < 6);
            doClr = ($urandom_range(0, 9) == 0);
            if (doRst) rdCount = 0;
            else if (rdCount < mWr && $urandom_range(0, 9) < 4) rdCount++;
            applyStimulus(doInc, doClr, doRst, rdCount);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
